// File: rtl/warmboot_pkg.sv
// Shared definitions for the warm-boot sequencer: FSM state encoding and the
// slot-index to flash-address mapping used when commanding the bitstream loader.
package warmboot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_FAILED  = 3'd4
  } state_t;

  // Width of the intermediate address arithmetic; callers truncate to their
  // own address width, which gives the modulo-2**ADDR_WIDTH wrap.
  localparam int unsigned ADDR_CALC_W = 32'd64;

  // Byte address of a slot: base + slot * 2**stride_log2.
  function automatic logic [ADDR_CALC_W-1:0] slot_to_addr(
    input logic [31:0]            slot,
    input int unsigned            stride_log2,
    input logic [ADDR_CALC_W-1:0] base
  );
    logic [ADDR_CALC_W-1:0] offset;
    offset = {32'd0, slot} << stride_log2;
    return base + offset;
  endfunction

endpackage

// File: rtl/warmboot_sync.sv
// Brings the asynchronous fabric boot request into the CLK domain through a
// two-flop synchronizer and flags the cycle in which the synchronized level rises.
module warmboot_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Two synchronizer stages plus a delayed copy used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/warmboot_ctrl.sv
// Warm-boot sequencer. Holds the fabric in reset, starts the bitstream loader at
// the selected slot's flash address, retries once from the default slot on a
// failed or timed-out load, and releases reset one cycle after CONFIGURED rises.
module warmboot_ctrl
  import warmboot_pkg::*;
#(
  parameter int unsigned          SLOT_BITS        = 32'd4,
  parameter int unsigned          ADDR_WIDTH       = 32'd24,
  parameter int unsigned          SLOT_STRIDE_LOG2 = 32'd20,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = {ADDR_WIDTH{1'b0}},
  parameter int unsigned          DEFAULT_SLOT     = 32'd0,
  parameter int unsigned          RESET_CYCLES     = 32'd16,
  parameter int unsigned          TIMEOUT_CYCLES   = 32'd16777216
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [SLOT_BITS-1:0]  SLOT_top,
  input  logic                  BOOT_top,
  output logic                  RESET_top,
  output logic                  CONFIGURED_top,
  output logic                  cfg_start,
  output logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic                  cfg_done,
  input  logic                  cfg_error,
  output logic [SLOT_BITS-1:0]  active_slot,
  output logic                  boot_failed
);

  // Slot field plus stride must fit in the loader address, and the hold
  // phase needs at least one cycle.
  if (SLOT_BITS + SLOT_STRIDE_LOG2 > ADDR_WIDTH) begin : g_addr_width_check
    $error("warmboot_ctrl: SLOT_BITS + SLOT_STRIDE_LOG2 exceeds ADDR_WIDTH");
  end
  if (RESET_CYCLES < 32'd1) begin : g_reset_cycles_check
    $error("warmboot_ctrl: RESET_CYCLES must be at least 1");
  end

  localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 32'd1);
  localparam int unsigned WD_W   = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 32'd1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic              WD_EN     = (TIMEOUT_CYCLES != 32'd0);

  // Synchronized boot request edge
  logic boot_rise_s;

  // FSM and datapath registers
  state_t                state_r;
  logic [HOLD_W-1:0]     hold_cnt_r;
  logic [WD_W-1:0]       wd_cnt_r;
  logic                  fallback_r;
  logic [SLOT_BITS-1:0]  active_slot_r;
  logic [ADDR_WIDTH-1:0] cfg_addr_r;
  logic                  cfg_start_r;
  logic                  reset_top_r;
  logic                  configured_r;
  logic                  boot_failed_r;

  // Next-state values
  state_t                state_nxt_s;
  logic [HOLD_W-1:0]     hold_cnt_nxt_s;
  logic [WD_W-1:0]       wd_cnt_nxt_s;
  logic                  fallback_nxt_s;
  logic [SLOT_BITS-1:0]  slot_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_nxt_s;
  logic                  start_nxt_s;

  // Loader outcome qualifiers
  logic wd_expired_s;
  logic load_ok_s;
  logic load_fail_s;

  warmboot_sync u_boot_sync (
    .clk  (CLK),
    .rst  (RST),
    .d    (BOOT_top),
    .rise (boot_rise_s)
  );

  // A good completion in the expiry cycle takes precedence over the watchdog.
  assign wd_expired_s = WD_EN & (wd_cnt_r == WD_LAST);
  assign load_ok_s    = cfg_done & ~cfg_error;
  assign load_fail_s  = (cfg_done & cfg_error) | wd_expired_s;

  // Next-state and datapath update decisions for the boot sequence
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    wd_cnt_nxt_s   = wd_cnt_r;
    fallback_nxt_s = fallback_r;
    slot_nxt_s     = active_slot_r;
    addr_nxt_s     = cfg_addr_r;
    start_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Slot is captured in the same cycle as the synchronized edge.
        if (boot_rise_s) begin
          state_nxt_s    = ST_HOLD;
          hold_cnt_nxt_s = {HOLD_W{1'b0}};
          fallback_nxt_s = 1'b0;
          slot_nxt_s     = SLOT_top;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_nxt_s  = ST_WAIT;
          start_nxt_s  = 1'b1;
          wd_cnt_nxt_s = {WD_W{1'b0}};
          addr_nxt_s   = ADDR_WIDTH'(slot_to_addr(32'(active_slot_r), SLOT_STRIDE_LOG2,
                                                  ADDR_CALC_W'(BASE_ADDR)));
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(32'd1);
        end
      end
      ST_WAIT: begin
        if (load_ok_s) begin
          state_nxt_s = ST_RELEASE;
        end else if (load_fail_s) begin
          if (fallback_r) begin
            state_nxt_s = ST_FAILED;
          end else begin
            state_nxt_s    = ST_HOLD;
            fallback_nxt_s = 1'b1;
            slot_nxt_s     = SLOT_BITS'(DEFAULT_SLOT);
            hold_cnt_nxt_s = {HOLD_W{1'b0}};
          end
        end else begin
          wd_cnt_nxt_s = wd_cnt_r + WD_W'(32'd1);
        end
      end
      ST_RELEASE: begin
        state_nxt_s = ST_IDLE;
      end
      ST_FAILED: begin
        state_nxt_s = ST_FAILED;
      end
      default: begin
        // An unreachable encoding keeps the fabric parked in reset.
        state_nxt_s = ST_FAILED;
      end
    endcase
  end

  // FSM state register; reset enters the power-on load
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_HOLD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Counters, slot/fallback tracking and loader command registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_cnt_r    <= {HOLD_W{1'b0}};
      wd_cnt_r      <= {WD_W{1'b0}};
      fallback_r    <= 1'b1;
      active_slot_r <= SLOT_BITS'(DEFAULT_SLOT);
      cfg_addr_r    <= {ADDR_WIDTH{1'b0}};
      cfg_start_r   <= 1'b0;
    end else begin
      hold_cnt_r    <= hold_cnt_nxt_s;
      wd_cnt_r      <= wd_cnt_nxt_s;
      fallback_r    <= fallback_nxt_s;
      active_slot_r <= slot_nxt_s;
      cfg_addr_r    <= addr_nxt_s;
      cfg_start_r   <= start_nxt_s;
    end
  end

  // Fabric-facing flags registered from the upcoming state so they line up with it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      reset_top_r   <= 1'b1;
      configured_r  <= 1'b0;
      boot_failed_r <= 1'b0;
    end else begin
      reset_top_r   <= (state_nxt_s != ST_IDLE);
      configured_r  <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_RELEASE);
      boot_failed_r <= (state_nxt_s == ST_FAILED);
    end
  end

  assign RESET_top      = reset_top_r;
  assign CONFIGURED_top = configured_r;
  assign cfg_start      = cfg_start_r;
  assign cfg_addr       = cfg_addr_r;
  assign active_slot    = active_slot_r;
  assign boot_failed    = boot_failed_r;

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Self-checking bench for warmboot_ctrl: directed scenarios plus randomized boot
// attempts checked against a small outcome model of the sequencer.
module tb_warmboot_ctrl;

  localparam int RC = 16;   // RESET_CYCLES
  localparam int T  = 100;  // TIMEOUT_CYCLES
  localparam int OUT_GOOD = 0, OUT_ERR = 1, OUT_SILENT = 2;

  logic        CLK, RST, BOOT_top, cfg_done, cfg_error;
  logic [3:0]  SLOT_top;
  logic        RESET_top, CONFIGURED_top, cfg_start, boot_failed;
  logic [23:0] cfg_addr;
  logic [3:0]  active_slot;

  int vectors = 0;
  int miscompares = 0;
  int start_count = 0;

  warmboot_ctrl #(
    .SLOT_BITS(32'd4), .ADDR_WIDTH(32'd24), .SLOT_STRIDE_LOG2(32'd20),
    .BASE_ADDR(24'h000000), .DEFAULT_SLOT(32'd0),
    .RESET_CYCLES(32'd16), .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .CLK(CLK), .RST(RST), .SLOT_top(SLOT_top), .BOOT_top(BOOT_top),
    .RESET_top(RESET_top), .CONFIGURED_top(CONFIGURED_top),
    .cfg_start(cfg_start), .cfg_addr(cfg_addr),
    .cfg_done(cfg_done), .cfg_error(cfg_error),
    .active_slot(active_slot), .boot_failed(boot_failed)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // Expected loader address of a slot: slot * 1 MiB, modulo 2**24.
  function automatic logic [23:0] model_addr(input int slot);
    int a;
    a = (slot * (1 << 20)) % (1 << 24);
    return a[23:0];
  endfunction

  // One clock: advance to the falling edge, where outputs are observed.
  task automatic tick();
    @(negedge CLK);
    if (cfg_start === 1'b1) start_count++;
  endtask

  task automatic wait_for_start(input int budget, output bit seen, output int waited);
    seen = 1'b0; waited = 0;
    while (!seen && waited < budget) begin
      tick(); waited++;
      if (cfg_start === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_reset_high(input int budget, output bit seen, output int waited);
    seen = 1'b0; waited = 0;
    while (!seen && waited < budget) begin
      tick(); waited++;
      if (RESET_top === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic pulse_done(input bit err);
    cfg_done = 1'b1; cfg_error = err;
    tick();
    cfg_done = 1'b0; cfg_error = 1'b0;
  endtask

  task automatic recover_por();
    bit s; int w;
    RST = 1'b1; tick(); RST = 1'b0;
    wait_for_start(RC + 5, s, w);
    repeat (3) tick();
    pulse_done(1'b0);
    tick(); tick();
  endtask

  task automatic test_reset();
    RST = 1'b1; BOOT_top = 1'b0; SLOT_top = 4'd0; cfg_done = 1'b0; cfg_error = 1'b0;
    tick(); tick();
    vectors++; if (RESET_top !== 1'b1) begin miscompares++; $display("FAIL rst_reset_top: got %b want 1", RESET_top); end
    vectors++; if (CONFIGURED_top !== 1'b0) begin miscompares++; $display("FAIL rst_configured: got %b want 0", CONFIGURED_top); end
    vectors++; if (cfg_start !== 1'b0) begin miscompares++; $display("FAIL rst_cfg_start: got %b want 0", cfg_start); end
    vectors++; if (cfg_addr !== 24'h0) begin miscompares++; $display("FAIL rst_cfg_addr: got %h want 000000", cfg_addr); end
    vectors++; if (active_slot !== 4'd0) begin miscompares++; $display("FAIL rst_active_slot: got %0d want 0", active_slot); end
    vectors++; if (boot_failed !== 1'b0) begin miscompares++; $display("FAIL rst_boot_failed: got %b want 0", boot_failed); end
  endtask

  task automatic test_por();
    bit s; int w; int s0;
    s0 = start_count;
    RST = 1'b0;
    wait_for_start(RC + 5, s, w);
    vectors++; if (!s || w != RC + 1) begin miscompares++; $display("FAIL por_start_cycle: got %0d want %0d", s ? w : -1, RC + 1); end
    vectors++; if (cfg_addr !== 24'h000000) begin miscompares++; $display("FAIL por_cfg_addr: got %h want 000000", cfg_addr); end
    tick();
    vectors++; if (cfg_start !== 1'b0) begin miscompares++; $display("FAIL por_start_width: got %b want 0", cfg_start); end
    repeat (39 - (RC + 2)) tick();
    pulse_done(1'b0);
    vectors++; if (CONFIGURED_top !== 1'b1 || RESET_top !== 1'b1) begin miscompares++; $display("FAIL por_release_order: got cfg=%b rst=%b want 1 1", CONFIGURED_top, RESET_top); end
    tick();
    vectors++; if (CONFIGURED_top !== 1'b1 || RESET_top !== 1'b0) begin miscompares++; $display("FAIL por_idle: got cfg=%b rst=%b want 1 0", CONFIGURED_top, RESET_top); end
    vectors++; if (start_count - s0 != 1) begin miscompares++; $display("FAIL por_start_count: got %0d want 1", start_count - s0); end
  endtask

  task automatic test_warm_boot();
    bit s; int w;
    SLOT_top = 4'd3; BOOT_top = 1'b1;
    wait_reset_high(4, s, w);
    vectors++; if (!s) begin miscompares++; $display("FAIL wb_reset_latency: got none want RESET_top=1 within 4"); end
    vectors++; if (active_slot !== 4'd3 || CONFIGURED_top !== 1'b0) begin miscompares++; $display("FAIL wb_entry: got slot=%0d cfg=%b want 3 0", active_slot, CONFIGURED_top); end
    BOOT_top = 1'b0;
    wait_for_start(RC + 5, s, w);
    vectors++; if (!s || w != RC + 1) begin miscompares++; $display("FAIL wb_start_cycle: got %0d want %0d", s ? w : -1, RC + 1); end
    vectors++; if (cfg_addr !== 24'h300000) begin miscompares++; $display("FAIL wb_cfg_addr: got %h want 300000", cfg_addr); end
    repeat (10) tick();
    pulse_done(1'b0);
    vectors++; if (CONFIGURED_top !== 1'b1 || RESET_top !== 1'b1) begin miscompares++; $display("FAIL wb_release: got cfg=%b rst=%b want 1 1", CONFIGURED_top, RESET_top); end
    tick();
    vectors++; if (RESET_top !== 1'b0 || active_slot !== 4'd3) begin miscompares++; $display("FAIL wb_idle: got rst=%b slot=%0d want 0 3", RESET_top, active_slot); end
  endtask

  task automatic test_fallback();
    bit s; int w; int slots[2];
    slots[0] = 5; slots[1] = 0;
    foreach (slots[i]) begin
      SLOT_top = 4'(slots[i]); BOOT_top = 1'b1;
      wait_reset_high(4, s, w);
      BOOT_top = 1'b0;
      wait_for_start(RC + 5, s, w);
      vectors++; if (!s || cfg_addr !== model_addr(slots[i])) begin miscompares++; $display("FAIL fb_first_addr: got %h want %h", cfg_addr, model_addr(slots[i])); end
      repeat (3) tick();
      pulse_done(1'b1);
      vectors++; if (RESET_top !== 1'b1 || CONFIGURED_top !== 1'b0) begin miscompares++; $display("FAIL fb_retry_hold: got rst=%b cfg=%b want 1 0", RESET_top, CONFIGURED_top); end
      wait_for_start(RC + 5, s, w);
      vectors++; if (!s || w != RC + 1) begin miscompares++; $display("FAIL fb_retry_cycle: got %0d want %0d", s ? w : -1, RC + 1); end
      vectors++; if (cfg_addr !== 24'h000000 || active_slot !== 4'd0) begin miscompares++; $display("FAIL fb_retry_addr: got %h slot %0d want 000000 0", cfg_addr, active_slot); end
      repeat (5) tick();
      pulse_done(1'b0);
      tick();
      vectors++; if (RESET_top !== 1'b0 || boot_failed !== 1'b0 || active_slot !== 4'd0) begin miscompares++; $display("FAIL fb_done: got rst=%b bf=%b slot=%0d want 0 0 0", RESET_top, boot_failed, active_slot); end
    end
  endtask

  task automatic test_double_failure();
    bit s; int w; int s0;
    SLOT_top = 4'd2; BOOT_top = 1'b1;
    wait_reset_high(4, s, w);
    BOOT_top = 1'b0;
    wait_for_start(RC + 5, s, w);
    vectors++; if (!s || cfg_addr !== 24'h200000) begin miscompares++; $display("FAIL df_first_addr: got %h want 200000", cfg_addr); end
    s0 = start_count;
    wait_for_start(T + RC + 10, s, w);
    vectors++; if (!s || w != T + RC + 1) begin miscompares++; $display("FAIL df_timeout_retry: got %0d want %0d", s ? w : -1, T + RC + 1); end
    vectors++; if (cfg_addr !== 24'h000000) begin miscompares++; $display("FAIL df_retry_addr: got %h want 000000", cfg_addr); end
    repeat (T - 1) tick();
    vectors++; if (boot_failed !== 1'b0) begin miscompares++; $display("FAIL df_early_fail: got %b want 0", boot_failed); end
    tick();
    vectors++; if (boot_failed !== 1'b1 || RESET_top !== 1'b1 || CONFIGURED_top !== 1'b0) begin miscompares++; $display("FAIL df_failed: got bf=%b rst=%b cfg=%b want 1 1 0", boot_failed, RESET_top, CONFIGURED_top); end
    pulse_done(1'b0);
    SLOT_top = 4'd9; BOOT_top = 1'b1;
    repeat (30) tick();
    BOOT_top = 1'b0;
    vectors++; if (boot_failed !== 1'b1 || RESET_top !== 1'b1 || start_count - s0 != 1) begin miscompares++; $display("FAIL df_sticky: got bf=%b rst=%b starts=%0d want 1 1 1", boot_failed, RESET_top, start_count - s0); end
    recover_por();
    vectors++; if (boot_failed !== 1'b0 || RESET_top !== 1'b0) begin miscompares++; $display("FAIL df_recover: got bf=%b rst=%b want 0 0", boot_failed, RESET_top); end
  endtask

  task automatic test_watchdog_edge();
    bit s; int w;
    SLOT_top = 4'd7; BOOT_top = 1'b1;
    wait_reset_high(4, s, w);
    BOOT_top = 1'b0;
    wait_for_start(RC + 5, s, w);
    repeat (T - 1) tick();
    pulse_done(1'b0);
    vectors++; if (CONFIGURED_top !== 1'b1) begin miscompares++; $display("FAIL wd_done_wins: got cfg=%b want 1", CONFIGURED_top); end
    tick();
    vectors++; if (RESET_top !== 1'b0 || active_slot !== 4'd7) begin miscompares++; $display("FAIL wd_idle: got rst=%b slot=%0d want 0 7", RESET_top, active_slot); end
  endtask

  task automatic test_back_to_back_requests();
    bit s; int w; int s0;
    s0 = start_count;
    SLOT_top = 4'd6; BOOT_top = 1'b1;
    wait_reset_high(4, s, w);
    SLOT_top = 4'd9; BOOT_top = 1'b0;
    repeat (4) tick();
    BOOT_top = 1'b1;
    repeat (4) tick();
    BOOT_top = 1'b0;
    wait_for_start(RC + 5, s, w);
    vectors++; if (!s || cfg_addr !== 24'h600000 || active_slot !== 4'd6) begin miscompares++; $display("FAIL b2b_addr: got %h slot %0d want 600000 6", cfg_addr, active_slot); end
    BOOT_top = 1'b1;
    repeat (4) tick();
    BOOT_top = 1'b0;
    repeat (4) tick();
    vectors++; if (cfg_addr !== 24'h600000) begin miscompares++; $display("FAIL b2b_addr_stable: got %h want 600000", cfg_addr); end
    pulse_done(1'b0);
    tick();
    repeat (20) tick();
    vectors++; if (start_count - s0 != 1 || RESET_top !== 1'b0) begin miscompares++; $display("FAIL b2b_no_extra: got starts=%0d rst=%b want 1 0", start_count - s0, RESET_top); end
  endtask

  task automatic test_rst_in_wait();
    bit s; int w;
    SLOT_top = 4'd4; BOOT_top = 1'b1;
    wait_reset_high(4, s, w);
    BOOT_top = 1'b0;
    wait_for_start(RC + 5, s, w);
    repeat (5) tick();
    #2 RST = 1'b1;
    #1;
    vectors++; if (RESET_top !== 1'b1 || CONFIGURED_top !== 1'b0 || cfg_start !== 1'b0) begin miscompares++; $display("FAIL rw_flags: got rst=%b cfg=%b start=%b want 1 0 0", RESET_top, CONFIGURED_top, cfg_start); end
    vectors++; if (cfg_addr !== 24'h0 || active_slot !== 4'd0 || boot_failed !== 1'b0) begin miscompares++; $display("FAIL rw_regs: got addr=%h slot=%0d bf=%b want 000000 0 0", cfg_addr, active_slot, boot_failed); end
    tick();
    RST = 1'b0;
    wait_for_start(RC + 5, s, w);
    vectors++; if (!s || w != RC + 1 || cfg_addr !== 24'h0) begin miscompares++; $display("FAIL rw_new_por: got cyc=%0d addr=%h want %0d 000000", s ? w : -1, cfg_addr, RC + 1); end
    repeat (5) tick();
    pulse_done(1'b0);
    tick();
    vectors++; if (RESET_top !== 1'b0) begin miscompares++; $display("FAIL rw_idle: got rst=%b want 0", RESET_top); end
  endtask

  task automatic test_random();
    bit s; int w;
    int slot, n, final_slot, d;
    int outc[2];
    logic [23:0] exp_addr[2];
    bit final_ok;
    for (int it = 0; it < 12; it++) begin
      slot = int'($urandom_range(0, 15));
      outc[0] = int'($urandom_range(0, 2));
      outc[1] = int'($urandom_range(0, 2));
      exp_addr[0] = model_addr(slot);
      exp_addr[1] = model_addr(0);
      n = (outc[0] == OUT_GOOD) ? 1 : 2;
      final_ok = (outc[0] == OUT_GOOD) || (outc[1] == OUT_GOOD);
      final_slot = (outc[0] == OUT_GOOD) ? slot : 0;
      SLOT_top = 4'(slot); BOOT_top = 1'b1;
      wait_reset_high(4, s, w);
      vectors++; if (!s || active_slot !== 4'(slot)) begin miscompares++; $display("FAIL rnd_request: got slot=%0d want %0d", active_slot, slot); end
      BOOT_top = 1'b0;
      for (int a = 0; a < n; a++) begin
        wait_for_start(RC + 5, s, w);
        vectors++; if (!s || w != RC + 1 || cfg_addr !== exp_addr[a]) begin miscompares++; $display("FAIL rnd_start: got cyc=%0d addr=%h want %0d %h", s ? w : -1, cfg_addr, RC + 1, exp_addr[a]); end
        if (outc[a] == OUT_SILENT) begin
          repeat (T) tick();
        end else begin
          d = int'($urandom_range(0, T - 2));
          repeat (d) tick();
          pulse_done(outc[a] == OUT_ERR);
        end
      end
      if (final_ok) begin
        vectors++; if (CONFIGURED_top !== 1'b1 || RESET_top !== 1'b1) begin miscompares++; $display("FAIL rnd_release: got cfg=%b rst=%b want 1 1", CONFIGURED_top, RESET_top); end
        tick();
        vectors++; if (RESET_top !== 1'b0 || active_slot !== 4'(final_slot)) begin miscompares++; $display("FAIL rnd_final: got rst=%b slot=%0d want 0 %0d", RESET_top, active_slot, final_slot); end
      end else begin
        vectors++; if (boot_failed !== 1'b1 || active_slot !== 4'd0) begin miscompares++; $display("FAIL rnd_failed: got bf=%b slot=%0d want 1 0", boot_failed, active_slot); end
        recover_por();
      end
    end
  endtask

  initial begin
    test_reset();
    test_por();
    test_warm_boot();
    test_fallback();
    test_double_failure();
    test_watchdog_edge();
    test_back_to_back_requests();
    test_rst_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
